dezigzag: RTL and testbench

DEZIGZAG -- requirements
Module: dezigzag

---
 rtl/dezigzag.sv | 218 +++++++++++++++++++++
 tb/tb_dezigzag.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dezigzag.sv
// Zigzag-to-raster reorder buffer for 8x8 coefficient blocks, ping-pong over two banks.
// Optional early end-of-block support is compiled in with `define DEZIGZAG_EOB_EN.
//
// bank state   | meaning
// BANK_EMPTY   | free, no coefficients written since last drain
// BANK_FILLING | write walker is part-way through this bank
// BANK_FULL    | block complete, waiting to be read or being read

module dezigzag #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
`ifdef DEZIGZAG_EOB_EN
  input  logic                  in_eob,
`endif
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            out_addr,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_e;

  bank_st_e bank_st_q [2];
  bank_st_e bank_st_d [2];

  logic            wr_bank_q, wr_bank_d;
  logic [2:0]      wr_x_q, wr_x_d;
  logic [2:0]      wr_y_q, wr_y_d;

  logic            rd_active_q, rd_active_d;
  logic            rd_bank_q, rd_bank_d;
  logic [5:0]      rd_idx_q, rd_idx_d;

  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [DATA_WIDTH-1:0] mem_q [2][64];

  logic                  wr_en;
  logic [5:0]            wr_addr;
  logic                  blk_done;
  logic                  parity;
  logic                  rd_xfer;
  logic                  rd_fin;
  logic                  rd_next_bank;
  logic [5:0]            rd_next_idx;
  logic [DATA_WIDTH-1:0] rd_word;

`ifdef DEZIGZAG_EOB_EN
  logic [63:0] wmask_q [2];
  logic [63:0] wmask_d [2];
`endif

  assign in_ready = (bank_st_q[wr_bank_q] != BANK_FULL);
  assign wr_en    = in_valid && in_ready;
  assign wr_addr  = {wr_y_q, wr_x_q};
  assign parity   = wr_x_q[0] ^ wr_y_q[0];

`ifdef DEZIGZAG_EOB_EN
  assign blk_done = ((wr_x_q == 3'd7) && (wr_y_q == 3'd7)) || in_eob;
`else
  assign blk_done = (wr_x_q == 3'd7) && (wr_y_q == 3'd7);
`endif

  // The read mux looks at the word that will be presented after this edge,
  // so the output register holds data and address together.
  assign rd_xfer      = out_valid_q && out_ready;
  assign rd_fin       = rd_xfer && (rd_idx_q == 6'd63);
  assign rd_next_idx  = rd_xfer ? (rd_idx_q + 6'd1) : rd_idx_q;
  assign rd_next_bank = rd_fin ? ~rd_bank_q : rd_bank_q;

`ifdef DEZIGZAG_EOB_EN
  assign rd_word = wmask_q[rd_next_bank][rd_next_idx] ? mem_q[rd_next_bank][rd_next_idx]
                                                      : '0;
`else
  assign rd_word = mem_q[rd_next_bank][rd_next_idx];
`endif

  always_comb begin
    bank_st_d   = bank_st_q;
    wr_bank_d   = wr_bank_q;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    rd_active_d = rd_active_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
`ifdef DEZIGZAG_EOB_EN
    wmask_d     = wmask_q;
`endif

    // Read side: one idle cycle after a bank turns FULL, then stream raster 0..63.
    if (!rd_active_q) begin
      if (bank_st_q[rd_bank_q] == BANK_FULL) begin
        rd_active_d = 1'b1;
      end
    end else if (!out_valid_q) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_word;
      out_last_d  = 1'b0;
    end else if (out_ready) begin
      rd_idx_d  = rd_next_idx;
      rd_bank_d = rd_next_bank;
      if (rd_fin) begin
        bank_st_d[rd_bank_q] = BANK_EMPTY;
`ifdef DEZIGZAG_EOB_EN
        wmask_d[rd_bank_q] = '0;
`endif
        // Chain straight into the other bank when it is already complete.
        if (bank_st_q[~rd_bank_q] == BANK_FULL) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_word;
        end else begin
          out_valid_d = 1'b0;
          rd_active_d = 1'b0;
        end
        out_last_d = 1'b0;
      end else begin
        out_data_d = rd_word;
        out_last_d = (rd_next_idx == 6'd63);
      end
    end

    // Write side never touches the bank being read: that bank is FULL, so in_ready is low for it.
    if (wr_en) begin
`ifdef DEZIGZAG_EOB_EN
      wmask_d[wr_bank_q][wr_addr] = 1'b1;
`endif
      if (blk_done) begin
        bank_st_d[wr_bank_q] = BANK_FULL;
        wr_bank_d            = ~wr_bank_q;
        wr_x_d               = 3'd0;
        wr_y_d               = 3'd0;
      end else begin
        bank_st_d[wr_bank_q] = BANK_FILLING;
        if (!parity) begin
          if (wr_x_q == 3'd7) begin
            wr_y_d = wr_y_q + 3'd1;
          end else if (wr_y_q == 3'd0) begin
            wr_x_d = wr_x_q + 3'd1;
          end else begin
            wr_x_d = wr_x_q + 3'd1;
            wr_y_d = wr_y_q - 3'd1;
          end
        end else begin
          if (wr_y_q == 3'd7) begin
            wr_x_d = wr_x_q + 3'd1;
          end else if (wr_x_q == 3'd0) begin
            wr_y_d = wr_y_q + 3'd1;
          end else begin
            wr_x_d = wr_x_q - 3'd1;
            wr_y_d = wr_y_q + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_bank_q    <= 1'b0;
      wr_x_q       <= 3'd0;
      wr_y_q       <= 3'd0;
      rd_active_q  <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= 6'd0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
`ifdef DEZIGZAG_EOB_EN
      wmask_q[0]   <= '0;
      wmask_q[1]   <= '0;
`endif
    end else begin
      bank_st_q   <= bank_st_d;
      wr_bank_q   <= wr_bank_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      rd_active_q <= rd_active_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
`ifdef DEZIGZAG_EOB_EN
      wmask_q     <= wmask_d;
`endif
    end
  end

  // Coefficient storage is not reset; stale contents are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_addr] <= in_data;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_addr  = rd_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dezigzag.sv
// Directed bench for dezigzag: reference zigzag table, expected-output queue, stall and occupancy checks.
module tb_dezigzag;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [5:0]    out_addr;
  logic          out_last;
`ifdef DEZIGZAG_EOB_EN
  logic          in_eob = 1'b0;
`endif

  dezigzag #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef DEZIGZAG_EOB_EN
    .in_eob    (in_eob),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // zigzag index -> raster index (JPEG order)
  int zz [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10,
                  17, 24, 32, 25, 18, 11,  4,  5,
                  12, 19, 26, 33, 40, 48, 41, 34,
                  27, 20, 13,  6,  7, 14, 21, 28,
                  35, 42, 49, 56, 57, 50, 43, 36,
                  29, 22, 15, 23, 30, 37, 44, 51,
                  58, 59, 52, 45, 38, 31, 39, 46,
                  53, 60, 61, 54, 47, 55, 62, 63};

  typedef struct packed {
    logic [DW-1:0] d;
    logic [5:0]    a;
    logic          l;
  } exp_t;

  typedef struct {
    logic [5:0]    addr;
    logic [DW-1:0] data;
    logic          last;
  } vec_t;

  vec_t          vecs [12];
  exp_t          exp_q [$];
  exp_t          exp_e;
  exp_t          stall_val;
  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  logic [DW-1:0] blk [64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int blocks_in = 0;
  int blocks_out = 0;
  int got_cnt = 0;
  int first_valid_cyc = -1;
  int last_acc_cyc = 0;
  bit chk_occ = 0;
  bit chk_gap = 0;
  bit mid_blk = 0;
  bit stall_prev = 0;
  bit prev_valid = 0;
  bit rand_rdy = 0;
  bit arm_lat = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic finish_summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic abort(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no progress expected progress", name);
    finish_summary();
  endtask

  // Output monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mid_blk    = 0;
      stall_prev = 0;
      prev_valid = 0;
    end else begin
      if (chk_occ) check("in_ready_occupancy", 32'(in_ready), 32'((blocks_in - blocks_out) < 2));
      if (stall_prev)
        check("stall_hold", {out_valid, out_data, out_addr, out_last},
              {1'b1, stall_val.d, stall_val.a, stall_val.l});
      if (chk_gap && mid_blk) check("no_gap_in_block", 32'(out_valid), 32'd1);
      if (arm_lat && out_valid && !prev_valid) begin
        first_valid_cyc = cyc;
        arm_lat = 0;
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        got_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got addr %0d data %0h, expected no output", out_addr, out_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("output", {out_data, out_addr, out_last}, {exp_e.d, exp_e.a, exp_e.l});
        end
        mid_blk = !out_last;
        if (out_last) blocks_out++;
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = '{d: out_data, a: out_addr, l: out_last};
      prev_valid = out_valid;
    end
  end

  // Sends blk[0..n-1] in zigzag order; pushes the expected raster block when it completes.
  task automatic send_block(input int n, input bit eob, input bit push);
    logic [DW-1:0] ras [64];
    bit acc;
    int budget;
    if (push) begin
      for (int r = 0; r < 64; r++) ras[r] = '0;
      for (int k = 0; k < n; k++) ras[zz[k]] = blk[k];
      for (int r = 0; r < 64; r++) exp_q.push_back('{d: ras[r], a: 6'(r), l: (r == 63)});
    end
    for (int k = 0; k < n; k++) begin
      in_data  = blk[k];
      in_valid = 1'b1;
`ifdef DEZIGZAG_EOB_EN
      in_eob   = eob && (k == n - 1);
`endif
      budget = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        if (acc && k == n - 1) last_acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        budget++;
      end while (!acc && budget < 2000);
      if (!acc) abort("input_accept_timeout");
    end
    in_valid = 1'b0;
`ifdef DEZIGZAG_EOB_EN
    in_eob = 1'b0;
`endif
    if (n == 64 || eob) blocks_in++;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) abort("output_drain_timeout");
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
`ifdef DEZIGZAG_EOB_EN
    in_eob = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.delete();
    got_d.delete();
    got_l.delete();
    blocks_in  = 0;
    blocks_out = 0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    vecs[0]  = '{addr: 6'd0,  data: 10'd0,  last: 1'b0};
    vecs[1]  = '{addr: 6'd1,  data: 10'd1,  last: 1'b0};
    vecs[2]  = '{addr: 6'd2,  data: 10'd5,  last: 1'b0};
    vecs[3]  = '{addr: 6'd3,  data: 10'd6,  last: 1'b0};
    vecs[4]  = '{addr: 6'd4,  data: 10'd14, last: 1'b0};
    vecs[5]  = '{addr: 6'd5,  data: 10'd15, last: 1'b0};
    vecs[6]  = '{addr: 6'd6,  data: 10'd27, last: 1'b0};
    vecs[7]  = '{addr: 6'd7,  data: 10'd28, last: 1'b0};
    vecs[8]  = '{addr: 6'd8,  data: 10'd2,  last: 1'b0};
    vecs[9]  = '{addr: 6'd9,  data: 10'd4,  last: 1'b0};
    vecs[10] = '{addr: 6'd62, data: 10'd62, last: 1'b0};
    vecs[11] = '{addr: 6'd63, data: 10'd63, last: 1'b1};

    out_ready = 1'b1;
    reset_dut();
    @(negedge clk);
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_last",  32'(out_last),  32'd0);
    check("reset_out_addr",  32'(out_addr),  32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    @(posedge clk);
    #1;
    chk_occ = 1;

    // Single block, data = zigzag index; latency from 64th accept to first out_valid.
    for (int k = 0; k < 64; k++) blk[k] = DW'(k);
    first_valid_cyc = -1;
    arm_lat = 1;
    send_block(64, 0, 1);
    wait_drain();
    lat = first_valid_cyc - last_acc_cyc;
    check("latency_min2", 32'(lat >= 2), 32'd1);
    check("latency_max3", 32'(lat <= 3), 32'd1);
    check("block_len", 32'(got_d.size()), 32'd64);
    if (got_d.size() == 64) begin
      for (int i = 0; i < 12; i++) begin
        check("raster_table_data", 32'(got_d[vecs[i].addr]), 32'(vecs[i].data));
        check("raster_table_last", 32'(got_l[vecs[i].addr]), 32'(vecs[i].last));
      end
    end

    // Three blocks back to back with out_ready held high.
    got_cnt = 0;
    chk_gap = 1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 64; k++) blk[k] = DW'((b * 64 + k) ^ 10'h155);
      send_block(64, 0, 1);
    end
    wait_drain();
    chk_gap = 0;
    check("b2b_output_count", 32'(got_cnt), 32'd192);

    // Ten blocks with random backpressure on the output.
    got_cnt = 0;
    rand_rdy = 1;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 64; k++) blk[k] = DW'($urandom);
      send_block(64, 0, 1);
    end
    wait_drain();
    rand_rdy = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    check("stall_output_count", 32'(got_cnt), 32'd640);

    // Partial block discarded by a mid-block reset.
    for (int k = 0; k < 64; k++) blk[k] = DW'(10'h3ff - k);
    send_block(30, 0, 0);
    reset_dut();
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_in_ready",  32'(in_ready),  32'd1);
    check("midreset_out_addr",  32'(out_addr),  32'd0);
    @(posedge clk);
    #1;
    got_cnt = 0;
    send_block(64, 0, 1);
    wait_drain();
    check("midreset_next_block", 32'(got_cnt), 32'd64);

`ifdef DEZIGZAG_EOB_EN
    // Early end of block, then a full block, then a short block in the same bank.
    got_cnt = 0;
    blk[0] = DW'(100);
    blk[1] = DW'(-5);
    blk[2] = DW'(7);
    send_block(3, 1, 1);
    for (int k = 0; k < 64; k++) blk[k] = DW'(k + 200);
    send_block(64, 0, 1);
    blk[0] = DW'(33);
    send_block(1, 1, 1);
    for (int k = 0; k < 64; k++) blk[k] = DW'(k * 3);
    send_block(64, 1, 1);
    wait_drain();
    check("eob_output_count", 32'(got_cnt), 32'd256);
`endif

    finish_summary();
  end

  initial begin
    #2000000;
    abort("global_watchdog");
  end

endmodule
